// File: rtl/pc_target_table_if.sv
// Write/lookup bus of pc_target_table.
// master: decoder/loader side that drives writes and lookups.
// slave : the table, which returns the registered lookup result.
interface pc_target_table_if #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned PC_W   = 10,
    parameter int unsigned PS_W   = 2
);
    // Write port
    logic              wr_en;
    logic [PS_W-1:0]   wr_prog;
    logic [ADDR_W-1:0] wr_addr;
    logic [PC_W-1:0]   wr_data;

    // Lookup request
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [PC_W-1:0]   cur_pc;

    // Lookup response
    logic [PC_W-1:0]   PC_target;
    logic              rd_valid;
    logic              hit;

    modport master (
        output wr_en, wr_prog, wr_addr, wr_data,
        output rd_en, rd_addr, cur_pc,
        input  PC_target, rd_valid, hit
    );

    modport slave (
        input  wr_en, wr_prog, wr_addr, wr_data,
        input  rd_en, rd_addr, cur_pc,
        output PC_target, rd_valid, hit
    );
endinterface

// File: rtl/pc_target_table.sv
// Banked, writable branch-target table with a program-state tracker.
// NUM_PROGS banks of 2**ADDR_W entries, each with a valid bit set on write.
// A rising edge on init advances prog_state (wrapping at NUM_PROGS-1); lookups
// use the current bank and return a registered result one cycle later.
// A same-cycle write to the looked-up entry is forwarded to the lookup.
// Optional feature, macro LUT_RELATIVE_EN: entries are signed offsets added to
// cur_pc; a miss returns cur_pc + 1. Without it entries are absolute targets.
module pc_target_table #(
    parameter int unsigned NUM_PROGS = 3,
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned PC_W      = 10,
    parameter int unsigned PS_W      = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            init,
    output logic [PS_W-1:0] prog_state,
    pc_target_table_if.slave bus
);

    localparam int unsigned Entries = 2 ** ADDR_W;
    // One extra bit so NUM_PROGS == 2**PS_W still compares correctly.
    localparam logic [PS_W:0]   NumProgsW = (PS_W + 1)'(NUM_PROGS);
    localparam logic [PS_W-1:0] LastProg  = PS_W'(NUM_PROGS - 1);

    // Table storage
    logic [PC_W-1:0]    entry_q [NUM_PROGS][Entries];
    logic [PC_W-1:0]    entry_d [NUM_PROGS][Entries];
    logic [Entries-1:0] valid_q [NUM_PROGS];
    logic [Entries-1:0] valid_d [NUM_PROGS];

    // Program tracker
    logic [PS_W-1:0] prog_state_q, prog_state_d;
    logic            init_q, init_d;
    logic            init_edge;

    // Lookup result registers
    logic [PC_W-1:0] pc_target_q, pc_target_d;
    logic            hit_q, hit_d;
    logic            rd_valid_q, rd_valid_d;

    // Lookup datapath
    logic            wr_ok;
    logic            fwd;
    logic [PC_W-1:0] rd_entry;
    logic            rd_vld;
    logic [PC_W-1:0] lu_value;
    logic            lu_hit;
    logic [PC_W-1:0] lu_target;

    assign wr_ok     = bus.wr_en && ({1'b0, bus.wr_prog} < NumProgsW);
    assign init_edge = init & ~init_q;

    // Program-state tracker: one advance per rising edge of init.
    always_comb begin
        init_d       = init;
        prog_state_d = prog_state_q;
        if (init_edge) begin
            prog_state_d = (prog_state_q == LastProg) ? '0 : prog_state_q + PS_W'(1);
        end
    end

    // Table write: store data and set valid for in-range banks only.
    always_comb begin
        entry_d = entry_q;
        valid_d = valid_q;
        if (wr_ok) begin
            for (int unsigned b = 0; b < NUM_PROGS; b++) begin
                for (int unsigned e = 0; e < Entries; e++) begin
                    if (bus.wr_prog == PS_W'(b) && bus.wr_addr == ADDR_W'(e)) begin
                        entry_d[b][e] = bus.wr_data;
                        valid_d[b][e] = 1'b1;
                    end
                end
            end
        end
    end

    // Read mux over the current bank.
    always_comb begin
        rd_entry = '0;
        rd_vld   = 1'b0;
        for (int unsigned b = 0; b < NUM_PROGS; b++) begin
            for (int unsigned e = 0; e < Entries; e++) begin
                if (prog_state_q == PS_W'(b) && bus.rd_addr == ADDR_W'(e)) begin
                    rd_entry = entry_q[b][e];
                    rd_vld   = valid_q[b][e];
                end
            end
        end
    end

    // Forward a same-cycle write to the entry being looked up.
    always_comb begin
        fwd      = wr_ok && (bus.wr_prog == prog_state_q) && (bus.wr_addr == bus.rd_addr);
        lu_value = fwd ? bus.wr_data : rd_entry;
        lu_hit   = fwd | rd_vld;
    end

`ifdef LUT_RELATIVE_EN
    // Relative mode: offset from cur_pc on a hit, fall-through on a miss.
    always_comb begin
        lu_target = lu_hit ? (bus.cur_pc + lu_value) : (bus.cur_pc + PC_W'(1));
    end
`else
    logic unused_cur_pc;
    assign unused_cur_pc = ^bus.cur_pc;

    // Absolute mode: stored target on a hit, zero on a miss.
    always_comb begin
        lu_target = lu_hit ? lu_value : '0;
    end
`endif

    // Output registers: update on a lookup, otherwise hold target and hit.
    always_comb begin
        rd_valid_d  = bus.rd_en;
        pc_target_d = pc_target_q;
        hit_d       = hit_q;
        if (bus.rd_en) begin
            pc_target_d = lu_target;
            hit_d       = lu_hit;
        end
    end

    // Table state flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < NUM_PROGS; b++) begin
                valid_q[b] <= '0;
                for (int unsigned e = 0; e < Entries; e++) begin
                    entry_q[b][e] <= '0;
                end
            end
        end else begin
            entry_q <= entry_d;
            valid_q <= valid_d;
        end
    end

    // Tracker and lookup-result flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_state_q <= '0;
            init_q       <= 1'b0;
            pc_target_q  <= '0;
            hit_q        <= 1'b0;
            rd_valid_q   <= 1'b0;
        end else begin
            prog_state_q <= prog_state_d;
            init_q       <= init_d;
            pc_target_q  <= pc_target_d;
            hit_q        <= hit_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    assign prog_state    = prog_state_q;
    assign bus.PC_target = pc_target_q;
    assign bus.hit       = hit_q;
    assign bus.rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_pc_target_table.sv
// Self-checking bench for pc_target_table: directed steps plus random traffic
// compared against an array-based reference model of the table.
module tb_pc_target_table;

    localparam int unsigned NUM_PROGS = 3;
    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned PC_W      = 10;
    localparam int unsigned PS_W      = 2;
    localparam int unsigned Entries   = 2 ** ADDR_W;

    logic            clk;
    logic            rst_n;
    logic            init;
    logic [PS_W-1:0] prog_state;

    pc_target_table_if #(.ADDR_W(ADDR_W), .PC_W(PC_W), .PS_W(PS_W)) bus ();

    pc_target_table #(
        .NUM_PROGS(NUM_PROGS),
        .ADDR_W   (ADDR_W),
        .PC_W     (PC_W),
        .PS_W     (PS_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init      (init),
        .prog_state(prog_state),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    logic [PC_W-1:0] tab_m [NUM_PROGS][Entries];
    bit              vld_m [NUM_PROGS][Entries];
    int unsigned     ps_m;
    bit              init_prev;
    logic [PC_W-1:0] exp_pc;
    logic            exp_hit;
    logic            exp_rv;

    int n_assert;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < NUM_PROGS; b++) begin
            for (int e = 0; e < Entries; e++) begin
                tab_m[b][e] = '0;
                vld_m[b][e] = 1'b0;
            end
        end
        ps_m      = 0;
        init_prev = 1'b0;
        exp_pc    = '0;
        exp_hit   = 1'b0;
        exp_rv    = 1'b0;
    endtask

    task automatic idle_inputs();
        init        = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_prog = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;
        bus.cur_pc  = '0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(exp_rv));
        chk({tag, ".hit"}, 32'(bus.hit), 32'(exp_hit));
        chk({tag, ".PC_target"}, 32'(bus.PC_target), 32'(exp_pc));
        chk({tag, ".prog_state"}, 32'(prog_state), 32'(ps_m));
    endtask

    // Predict the effect of the current inputs, clock once, then compare.
    task automatic tick(input string tag);
        bit              wr_ok;
        bit              h;
        logic [PC_W-1:0] v;
        int unsigned     wp;
        wp    = int'(bus.wr_prog);
        wr_ok = bus.wr_en && (wp < NUM_PROGS);
        if (bus.rd_en) begin
            if (wr_ok && wp == ps_m && bus.wr_addr == bus.rd_addr) begin
                h = 1'b1;
                v = bus.wr_data;
            end else begin
                h = vld_m[ps_m][bus.rd_addr];
                v = tab_m[ps_m][bus.rd_addr];
            end
`ifdef LUT_RELATIVE_EN
            exp_pc = h ? PC_W'(bus.cur_pc + v) : PC_W'(bus.cur_pc + 1);
`else
            exp_pc = h ? v : '0;
`endif
            exp_hit = h;
        end
        exp_rv = bus.rd_en;
        if (wr_ok) begin
            tab_m[wp][bus.wr_addr] = bus.wr_data;
            vld_m[wp][bus.wr_addr] = 1'b1;
        end
        if (init && !init_prev) ps_m = (ps_m + 1) % NUM_PROGS;
        init_prev = init;
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic write(input int prog, input int addr, input logic [PC_W-1:0] data);
        idle_inputs();
        bus.wr_en   = 1'b1;
        bus.wr_prog = PS_W'(prog);
        bus.wr_addr = ADDR_W'(addr);
        bus.wr_data = data;
        tick("write");
    endtask

    task automatic lookup(input int addr, input logic [PC_W-1:0] pc, input string tag);
        idle_inputs();
        bus.rd_en   = 1'b1;
        bus.rd_addr = ADDR_W'(addr);
        bus.cur_pc  = pc;
        tick(tag);
    endtask

    task automatic pulse_init();
        idle_inputs();
        init = 1'b1;
        tick("init_hi");
        init = 1'b0;
        tick("init_lo");
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        idle_inputs();
        model_reset();

        // Reset state
        #12;
        check_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First lookup after reset misses
        lookup(3, '0, "miss_after_reset");
`ifndef LUT_RELATIVE_EN
        chk("tp_miss_pc", 32'(bus.PC_target), 32'h0);
`endif

        // Two banks, same address
        write(0, 5, 10'h07A);
        write(1, 5, 10'h155);
        lookup(5, '0, "bank0_addr5");
`ifndef LUT_RELATIVE_EN
        chk("tp_bank0_pc", 32'(bus.PC_target), 32'h07A);
`endif
        pulse_init();
        lookup(5, '0, "bank1_addr5");
`ifndef LUT_RELATIVE_EN
        chk("tp_bank1_pc", 32'(bus.PC_target), 32'h155);
`endif
        chk("tp_bank1_ps", 32'(prog_state), 32'h1);

        // init held high for 4 cycles gives one advance
        idle_inputs();
        init = 1'b1;
        for (int i = 0; i < 4; i++) tick("init_held");
        init = 1'b0;
        tick("init_release");
        chk("tp_held_ps", 32'(prog_state), 32'h2);

        // Wrap to 0, then three pulses give 1, 2, 0
        pulse_init();
        for (int i = 0; i < 3; i++) pulse_init();
        chk("tp_wrap_ps", 32'(prog_state), 32'h0);

        // Same-cycle init edge and lookup uses the old bank
        idle_inputs();
        init        = 1'b1;
        bus.rd_en   = 1'b1;
        bus.rd_addr = ADDR_W'(5);
        tick("init_and_lookup");
        init = 1'b0;
        tick("init_and_lookup_lo");
        pulse_init();
        pulse_init();

        // Same-cycle write and lookup is forwarded
        idle_inputs();
        bus.wr_en   = 1'b1;
        bus.wr_prog = '0;
        bus.wr_addr = ADDR_W'(2);
        bus.wr_data = 10'h3FF;
        bus.rd_en   = 1'b1;
        bus.rd_addr = ADDR_W'(2);
        tick("forward");
        chk("tp_forward_hit", 32'(bus.hit), 32'h1);

        // Out-of-range bank is ignored
        write(3, 6, 10'h123);
        lookup(6, 10'h010, "oob_miss");
        chk("tp_oob_hit", 32'(bus.hit), 32'h0);

        // Hold behaviour when rd_en is low
        idle_inputs();
        tick("hold");

        // Back-to-back lookups over all addresses
        for (int a = 0; a < Entries; a++) write(0, a, PC_W'(a * 37 + 5));
        for (int a = 0; a < Entries; a++) lookup(a, PC_W'(a * 3), "b2b");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            idle_inputs();
            init        = ($urandom_range(0, 5) == 0);
            bus.wr_en   = $urandom_range(0, 1) == 1;
            bus.wr_prog = PS_W'($urandom_range(0, 3));
            bus.wr_addr = ADDR_W'($urandom);
            bus.wr_data = PC_W'($urandom);
            bus.rd_en   = $urandom_range(0, 3) != 0;
            bus.rd_addr = ADDR_W'($urandom);
            bus.cur_pc  = PC_W'($urandom);
            tick("random");
        end

        // Reset in the middle of a lookup stream
        lookup(1, 10'h020, "pre_reset");
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("mid_reset");
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick("post_reset_idle");
        chk("tp_no_stale_valid", 32'(bus.rd_valid), 32'h0);
        lookup(1, 10'h020, "post_reset_lookup");

`ifdef LUT_RELATIVE_EN
        // Signed offset with wrap, and miss at the top of the PC range
        write(0, 4, 10'h3FE);
        lookup(4, 10'h001, "rel_hit");
        chk("tp_rel_hit_pc", 32'(bus.PC_target), 32'h3FF);
        lookup(7, 10'h3FF, "rel_miss");
        chk("tp_rel_miss_pc", 32'(bus.PC_target), 32'h000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Guard against a hang
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
